ram_memory_lat: RTL and testbench
=================================

Name: ram_memory_lat

Overview:
- Parametrised, clocked successor to the combinational line-wide main-memory model.
- Backs the cache-refill path: one outstanding line request at a time, with a valid/ready handshake on both request and response.
- Access latency is programmable.
- After reset the block self-initialises every word to its own word index, so software and benches see the same known memory image.

Parameters:
- WORD_W, 32, width of one memory word in bits.
- WORDS_PER_LINE, 4, words per line; power of 2, >=1.
- ADDR_W, 26, width of the line address.
- DEPTH_WORDS, 4096, total words; power of 2, multiple of WORDS_PER_LINE. DEPTH_LINES = DEPTH_WORDS/WORDS_PER_LINE.
- LATENCY, 4, cycles from request acceptance to resp_valid; >=1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = write line, 0 = read line.
- req_addr  in  ADDR_W  line address.
- req_wdata  in  WORDS_PER_LINE*WORD_W  write line; word k at bits [k*WORD_W +: WORD_W].
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes response.
- resp_write  out  1  response acknowledges a write (rdata is don't-care).
- resp_rdata  out  WORDS_PER_LINE*WORD_W  read line, same layout as req_wdata.
- init_done  out  1  self-initialisation finished.

Behaviour:
- Reset asserted (async): state=INIT, line counter=0, latency counter=0. req_ready=0, resp_valid=0, resp_write=0, resp_rdata=0, init_done=0. Any in-flight request is dropped.
- Address map: line index = req_addr mod DEPTH_LINES (low bits only; higher bits ignored, so the address space wraps). Word k of the line is at word index line*WORDS_PER_LINE+k.
- State INIT: one line written per cycle. Word i gets value i, zero-extended or truncated to WORD_W. After DEPTH_LINES cycles go to IDLE. init_done rises on that transition and stays 1 until the next reset.
- State IDLE: req_ready=1. On req_valid&&req_ready, latch write flag, line index and wdata, load latency counter with LATENCY-1, and go to WAIT. A write commits to the array on this same acceptance edge.
- State WAIT: req_ready=0. Counter decrements each cycle. When the counter is 0, go to RESP: capture resp_rdata from the latched line (reads) and set resp_write from the latched flag. resp_valid rises exactly LATENCY cycles after the acceptance edge.
- State RESP: resp_valid=1 and resp_rdata is held stable until resp_valid&&resp_ready. On that handshake: resp_valid=0, return to IDLE. req_ready returns the following cycle; there is no same-cycle re-accept.
- Read-after-write to the same line returns the newly written data.
- Requests during INIT, WAIT or RESP are not accepted (req_ready=0). The requester must hold req_valid and its payload stable until accepted.
- Reset mid-INIT or mid-transaction: the init pass restarts from line 0, and memory is re-initialised entirely on the next pass.
- Only one transaction is ever outstanding; there is no reordering.

Optional Feature:
- Macro RAM_MEMORY_WMASK_EN.
- Defined: adds input port req_wmask (WORDS_PER_LINE bits). On a write, word k is updated only if req_wmask[k]=1; masked words keep their old value. Reads ignore the mask.
- Undefined: no req_wmask port; every write updates all WORDS_PER_LINE words.

Test Plan:
Bench parameters: WORD_W=32, WORDS_PER_LINE=4, DEPTH_WORDS=64, LATENCY=4.
- Init: release reset, count cycles -> init_done=1 after 16 cycles. req_ready=0 throughout init. Read line 3 -> resp_rdata={32'd15,32'd14,32'd13,32'd12}.
- Latency: read line 0 accepted at edge N -> resp_valid first high at edge N+4. With resp_ready held 0 for 5 cycles, resp_valid and data stay stable; data={3,2,1,0}.
- Write then read: write line 5 with {DEAD0003,DEAD0002,DEAD0001,DEAD0000} -> resp_write=1. Subsequent read of line 5 returns that exact value.
- Wrap: read req_addr=21 (21 mod 16 = 5) after the previous write -> same DEAD000x line returned.
- Reset mid-transaction: assert reset 2 cycles after accepting a read -> resp_valid=0 immediately. After release, init reruns, and line 5 reads back {23,22,21,20}.
- With RAM_MEMORY_WMASK_EN: write line 2 with all-ones data and mask 4'b0101 -> read returns {32'd11,FFFFFFFF,32'd9,FFFFFFFF}.

Source files
------------

// File: rtl/ram_memory_lat.sv
// Line-wide main memory with programmable access latency and a valid/ready handshake on request and response.
// Self-initialises word i to i after reset. Define RAM_MEMORY_WMASK_EN to add a per-word write mask port (req_wmask).
module ram_memory_lat #(
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 26,
  parameter int DEPTH_WORDS    = 4096,
  parameter int LATENCY        = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [ADDR_W-1:0]                req_addr,
  input  logic [WORDS_PER_LINE*WORD_W-1:0] req_wdata,
`ifdef RAM_MEMORY_WMASK_EN
  input  logic [WORDS_PER_LINE-1:0]        req_wmask,
`endif
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic                             resp_write,
  output logic [WORDS_PER_LINE*WORD_W-1:0] resp_rdata,
  output logic                             init_done
);

  localparam int DEPTH_LINES = DEPTH_WORDS / WORDS_PER_LINE;
  localparam int LINE_W      = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
  localparam int WIDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(DEPTH_LINES - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                             r_state;
  state_t                             w_next_state;
  logic [LINE_W-1:0]                  r_line_cnt;
  logic [CNT_W-1:0]                   r_lat_cnt;
  logic [LINE_W-1:0]                  r_line;
  logic                               r_write;
  logic                               r_resp_write;
  logic [WORDS_PER_LINE*WORD_W-1:0]   r_resp_rdata;
  logic                               r_init_done;
  logic [WORDS_PER_LINE*WORD_W-1:0]   w_line_rdata;
  logic [LINE_W-1:0]                  w_acc_line;
  logic [WORDS_PER_LINE-1:0]          w_wmask;
  logic                               w_accept;

  // NOTE: the array has no reset; the INIT pass rewrites every word instead.
  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

  function automatic logic [WIDX_W-1:0] word_idx(input logic [LINE_W-1:0] line, input int k);
    return WIDX_W'(int'(line) * WORDS_PER_LINE + k);
  endfunction

  // Upper address bits are ignored, so the line address space wraps.
  assign w_acc_line = LINE_W'(req_addr % DEPTH_LINES);
  assign w_accept   = (r_state == S_IDLE) && req_valid;

`ifdef RAM_MEMORY_WMASK_EN
  assign w_wmask = req_wmask;
`else
  assign w_wmask = '1;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_INIT;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    w_next_state = r_state;
    case (r_state)
      S_INIT:  if (r_line_cnt == LAST_LINE) w_next_state = S_IDLE;
      S_IDLE:  if (req_valid)               w_next_state = S_WAIT;
      S_WAIT:  if (r_lat_cnt == '0)         w_next_state = S_RESP;
      S_RESP:  if (resp_ready)              w_next_state = S_IDLE;
      default:                              w_next_state = S_INIT;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready  = (r_state == S_IDLE);
    resp_valid = (r_state == S_RESP);
    resp_write = r_resp_write;
    resp_rdata = r_resp_rdata;
    init_done  = r_init_done;
  end

  // Memory write port: init pattern or accepted write request.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      for (int k = 0; k < WORDS_PER_LINE; k++)
        r_mem[word_idx(r_line_cnt, k)] <= WORD_W'(word_idx(r_line_cnt, k));
    end else if (w_accept && req_write) begin
      for (int k = 0; k < WORDS_PER_LINE; k++)
        if (w_wmask[k]) r_mem[word_idx(w_acc_line, k)] <= req_wdata[k*WORD_W +: WORD_W];
    end
  end

  always_comb begin
    w_line_rdata = '0;
    for (int k = 0; k < WORDS_PER_LINE; k++)
      w_line_rdata[k*WORD_W +: WORD_W] = r_mem[word_idx(r_line, k)];
  end

  // Transaction datapath and counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_line_cnt   <= '0;
      r_lat_cnt    <= '0;
      r_line       <= '0;
      r_write      <= 1'b0;
      r_resp_write <= 1'b0;
      r_resp_rdata <= '0;
      r_init_done  <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_line_cnt <= r_line_cnt + LINE_W'(1);
          if (r_line_cnt == LAST_LINE) r_init_done <= 1'b1;
        end
        S_IDLE: begin
          if (req_valid) begin
            r_write   <= req_write;
            r_line    <= w_acc_line;
            r_lat_cnt <= CNT_W'(LATENCY - 1);
          end
        end
        S_WAIT: begin
          if (r_lat_cnt != '0) begin
            r_lat_cnt <= r_lat_cnt - CNT_W'(1);
          end else begin
            r_resp_write <= r_write;
            if (!r_write) r_resp_rdata <= w_line_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_memory_lat.sv
// Self-checking bench for ram_memory_lat: directed init/latency/wrap/reset cases plus random traffic,
// with a scoreboard fed from a word-array reference model and drained by an independent response monitor.
module tb_ram_memory_lat;

  localparam int WORD_W      = 32;
  localparam int WPL         = 4;
  localparam int ADDR_W      = 26;
  localparam int DEPTH_WORDS = 64;
  localparam int DEPTH_LINES = DEPTH_WORDS / WPL;
  localparam int LAT         = 4;
  localparam int LB          = WPL * WORD_W;
  localparam int BUDGET      = 100;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [LB-1:0]     req_wdata = '0;
`ifdef RAM_MEMORY_WMASK_EN
  logic [WPL-1:0]    req_wmask = '0;
`endif
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic              resp_write;
  logic [LB-1:0]     resp_rdata;
  logic              init_done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          write;
    logic [LB-1:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [DEPTH_WORDS];

  ram_memory_lat #(
    .WORD_W(WORD_W), .WORDS_PER_LINE(WPL), .ADDR_W(ADDR_W),
    .DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef RAM_MEMORY_WMASK_EN
    .req_wmask(req_wmask),
`endif
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_rdata(resp_rdata), .init_done(init_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: memory as a flat word array, word i of a fresh image equals i.
  task automatic model_init();
    for (int i = 0; i < DEPTH_WORDS; i++) model_mem[i] = i;
  endtask

  function automatic logic [LB-1:0] model_line(input int line);
    logic [LB-1:0] r;
    for (int k = 0; k < WPL; k++) r[k*WORD_W +: WORD_W] = model_mem[line*WPL + k];
    return r;
  endfunction

  // Response monitor: every delivered response must match the oldest expectation.
  always @(negedge clk) begin
    if (reset && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got response write=%0b with empty scoreboard, expected none", resp_write);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_write", LB'(resp_write), LB'(e.write));
        if (!e.write) check("resp_rdata", resp_rdata, e.rdata);
      end
    end
  end

  // Assert reset at the current time, check reset outputs, release and time the init pass.
  task automatic do_reset();
    int n;
    #1;
    reset      = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    exp_q.delete();
    model_init();
    #1;
    check("rst_resp_valid", LB'(resp_valid), '0);
    check("rst_req_ready",  LB'(req_ready),  '0);
    check("rst_init_done",  LB'(init_done),  '0);
    check("rst_resp_write", LB'(resp_write), '0);
    check("rst_resp_rdata", resp_rdata,      '0);
    @(posedge clk);
    #1 reset = 1'b1;
    n = 0;
    while (!init_done && n < BUDGET) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!init_done) check("init_req_ready", LB'(req_ready), '0);
    end
    check("init_cycles", LB'(n), LB'(DEPTH_LINES));
    check("post_init_req_ready", LB'(req_ready), LB'(1));
  endtask

  // Present a request, wait for acceptance, push the model's expected response.
  task automatic accept_only(input logic wr, input logic [ADDR_W-1:0] addr,
                             input logic [LB-1:0] wdata, input logic [WPL-1:0] wmask);
    int   n;
    int   line;
    exp_t e;
    logic [WPL-1:0] eff_mask;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
`ifdef RAM_MEMORY_WMASK_EN
    req_wmask = wmask;
    eff_mask  = wmask;
`else
    eff_mask  = wmask | {WPL{1'b1}};
`endif
    n = 0;
    @(negedge clk);
    while (!req_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) check("accept_timeout", LB'(req_ready), LB'(1));
    @(posedge clk);
    line = int'(addr % DEPTH_LINES);
    if (wr) begin
      for (int k = 0; k < WPL; k++)
        if (eff_mask[k]) model_mem[line*WPL + k] = wdata[k*WORD_W +: WORD_W];
      e.write = 1'b1;
      e.rdata = '0;
    end else begin
      e.write = 1'b0;
      e.rdata = model_line(line);
    end
    exp_q.push_back(e);
    #1 req_valid = 1'b0;
  endtask

  // Full transaction: latency, stall stability for `hold` cycles, handshake and return to idle.
  task automatic send(input logic wr, input logic [ADDR_W-1:0] addr, input logic [LB-1:0] wdata,
                      input logic [WPL-1:0] wmask, input int hold, output logic [LB-1:0] rdata_seen);
    int            lat;
    logic [LB-1:0] first;
    accept_only(wr, addr, wdata, wmask);
    lat = 0;
    @(negedge clk);
    while (!resp_valid && lat < BUDGET) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", LB'(lat), LB'(LAT));
    check("resp_req_ready", LB'(req_ready), '0);
    first = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("stall_valid", LB'(resp_valid), LB'(1));
      check("stall_data", resp_rdata, first);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check("post_hs_valid", LB'(resp_valid), '0);
    check("post_hs_req_ready", LB'(req_ready), LB'(1));
    rdata_seen = first;
  endtask

  logic [LB-1:0] dead_line;
  logic [LB-1:0] got;

  initial begin
    dead_line = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000};

    do_reset();

    send(1'b0, 26'd3, '0, '0, 1, got);
    check("init_line3", got, {32'd15, 32'd14, 32'd13, 32'd12});

    send(1'b0, 26'd0, '0, '0, 5, got);
    check("line0", got, {32'd3, 32'd2, 32'd1, 32'd0});

    send(1'b1, 26'd5, dead_line, '1, 2, got);
    send(1'b0, 26'd5, '0, '0, 0, got);
    check("raw_line5", got, dead_line);

    send(1'b0, 26'd21, '0, '0, 1, got);
    check("wrap_addr21", got, dead_line);

    send(1'b0, 26'h3FFFFF5, '0, '0, 0, got);
    check("wrap_high_bits", got, dead_line);

`ifdef RAM_MEMORY_WMASK_EN
    send(1'b1, 26'd2, '1, 4'b0101, 0, got);
    send(1'b0, 26'd2, '0, '0, 0, got);
    check("wmask_line2", got, {32'd11, 32'hFFFFFFFF, 32'd9, 32'hFFFFFFFF});
`endif

    // Reset two cycles into a read: the in-flight request must vanish and the image must be rebuilt.
    accept_only(1'b0, 26'd7, '0, '0);
    repeat (2) @(posedge clk);
    do_reset();
    send(1'b0, 26'd5, '0, '0, 0, got);
    check("reinit_line5", got, {32'd23, 32'd22, 32'd21, 32'd20});

    for (int t = 0; t < 40; t++) begin
      logic [LB-1:0] wd;
      for (int k = 0; k < WPL; k++) wd[k*WORD_W +: WORD_W] = $urandom;
      send(1'($urandom_range(0, 1)), ADDR_W'($urandom), wd, WPL'($urandom_range(0, 15)),
           $urandom_range(0, 3), got);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drain", LB'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
